// File: rtl/bcd_scan_pkg.sv
// Shared digit type, BCD limits and a digit sanitiser for the BCD scan counter.
package bcd_scan_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_MAX = 4'd9;
  localparam digit_t DIGIT_MIN = 4'd0;

  // A nibble that is not a legal BCD digit is forced to zero.
  function automatic digit_t digit_sanitize(input digit_t d);
    return (d > DIGIT_MAX) ? DIGIT_MIN : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple chain: loads, steps up/down when its carry-in is set,
// and flags a carry/borrow out when it is about to wrap.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       cin,
  input  logic       load,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       cout
);

  import bcd_scan_pkg::*;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= DIGIT_MIN;
    end else if (load) begin
      q <= digit_sanitize(ld_val);
    end else if (step && cin) begin
      if (up) begin
        q <= (q == DIGIT_MAX) ? DIGIT_MIN : q + 4'd1;
      end else begin
        q <= (q == DIGIT_MIN) ? DIGIT_MAX : q - 4'd1;
      end
    end
  end

  // Carry/borrow leaves this digit only when it is stepped from its wrap value.
  assign cout = cin & (up ? (q == DIGIT_MAX) : (q == DIGIT_MIN));

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed digit scan for a shared decoder.
// Optional macro LEADING_ZERO_BLANK_EN blanks the select of leading zero digits (digit 0 never).
module bcd_scan_counter #(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  output logic [4*NDIG-1:0] count,
  output logic              carry,
  output logic [3:0]        bcd,
  output logic [NDIG-1:0]   an
);

  import bcd_scan_pkg::*;

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]   SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_RESET  = ~NDIG'(1);

  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic            step;
  logic [NDIG:0]   chain;
  logic [SW-1:0]   scan_cnt;
  logic [IW-1:0]   scan_idx;
  digit_t          sel_digit;
  logic [NDIG-1:0] an_next;

  assign tick = (tick_cnt == TICK_LAST);
  assign step = tick & en & ~load;

  // A load restarts the step period so the loaded value is held a full tick.
  always_ff @(posedge clk) begin
    if (rst || load || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign chain[0] = 1'b1;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .step   (step),
      .up     (up),
      .cin    (chain[g]),
      .load   (load),
      .ld_val (load_val[4*g +: 4]),
      .q      (count[4*g +: 4]),
      .cout   (chain[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
    end else begin
      carry <= step & chain[NDIG];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Digit value and its select come from the same index so they can never disagree.
  always_comb begin
    sel_digit = DIGIT_MIN;
    an_next   = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (scan_idx == IW'(i)) begin
        sel_digit  = count[4*i +: 4];
        an_next[i] = 1'b0;
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    begin : blank_calc
      logic zero_above;
      zero_above = 1'b1;
      for (int i = NDIG - 1; i >= 1; i--) begin
        zero_above = zero_above & (count[4*i +: 4] == DIGIT_MIN);
        if ((scan_idx == IW'(i)) && zero_above) begin
          an_next = '1;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd <= DIGIT_MIN;
      an  <= AN_RESET;
    end else begin
      bcd <= sel_digit;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter (NDIG=4, TICK_DIV=4, SCAN_DIV=2): decimal model plus directed literals.
module tb_bcd_scan_counter;

  localparam int NDIG     = 4;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        carry;
  logic [3:0]  bcd;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;

  bcd_scan_counter #(
    .NDIG     (NDIG),
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .carry    (carry),
    .bcd      (bcd),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: the count is held as a plain decimal integer.
  int       m_val   = 0;
  int       m_tdiv  = 0;
  int       m_sdiv  = 0;
  int       m_sidx  = 0;
  logic     m_carry = 1'b0;
  logic [3:0] m_bcd = 4'd0;
  logic [3:0] m_an  = 4'b1110;
  bit       m_valid = 1'b0;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int v;
    int d;
    v = 0;
    for (int i = 0; i < NDIG; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 0;
      v = v + d * pow10(i);
    end
    return v;
  endfunction

  always @(posedge clk) begin
    automatic bit tick;
    if (rst) begin
      m_val = 0; m_tdiv = 0; m_sdiv = 0; m_sidx = 0;
      m_carry = 1'b0; m_bcd = 4'd0; m_an = 4'b1110; m_valid = 1'b1;
    end else begin
      m_bcd = 4'((m_val / pow10(m_sidx)) % 10);
      m_an = 4'b1111;
      m_an[m_sidx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (m_sidx > 0 && (m_val / pow10(m_sidx)) == 0) m_an = 4'b1111;
`endif
      if (m_sdiv == SCAN_DIV - 1) begin
        m_sdiv = 0;
        m_sidx = (m_sidx + 1) % NDIG;
      end else begin
        m_sdiv = m_sdiv + 1;
      end
      m_carry = 1'b0;
      if (load) begin
        m_val  = from_load(load_val);
        m_tdiv = 0;
      end else begin
        tick   = (m_tdiv == TICK_DIV - 1);
        m_tdiv = (m_tdiv + 1) % TICK_DIV;
        if (tick && en) begin
          if (up) begin
            m_carry = (m_val == 9999);
            m_val   = (m_val + 1) % 10000;
          end else begin
            m_carry = (m_val == 0);
            m_val   = (m_val + 9999) % 10000;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic u, input logic l,
                               input logic [15:0] lv, input int n);
    rst = r; en = e; up = u; load = l; load_val = lv;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_count", 32'(count), 32'(to_bcd(m_val)));
      checkOutput("model_carry", 32'(carry), 32'(m_carry));
      checkOutput("model_bcd",   32'(bcd),   32'(m_bcd));
      checkOutput("model_an",    32'(an),    32'(m_an));
    end
  end

  initial begin
    logic [3:0] an_slot3;
`ifdef LEADING_ZERO_BLANK_EN
    an_slot3 = 4'b1111;
`else
    an_slot3 = 4'b0111;
`endif

    applyStimulus(1, 0, 1, 0, 16'h0000, 2);
    checkOutput("reset_count", 32'(count), 32'h0000);
    checkOutput("reset_an",    32'(an),    32'hE);
    checkOutput("reset_bcd",   32'(bcd),   32'h0);
    checkOutput("reset_carry", 32'(carry), 32'h0);
    applyStimulus(1, 1, 1, 0, 16'h5555, 10);
    checkOutput("reset_hold_count", 32'(count), 32'h0000);
    checkOutput("reset_hold_an",    32'(an),    32'hE);

    applyStimulus(0, 1, 1, 0, 16'h0000, 36);
    checkOutput("up_0009", 32'(count), 32'h0009);
    applyStimulus(0, 1, 1, 0, 16'h0000, 4);
    checkOutput("up_ripple_0010", 32'(count), 32'h0010);
    applyStimulus(0, 1, 1, 0, 16'h0000, 8);
    checkOutput("up_0012", 32'(count), 32'h0012);
    checkOutput("pin_model_0012", 32'(to_bcd(m_val)), 32'h0012);

    applyStimulus(0, 1, 1, 1, 16'h9999, 1);
    checkOutput("load_9999", 32'(count), 32'h9999);
    applyStimulus(0, 1, 1, 0, 16'h0000, 3);
    checkOutput("pre_wrap_count", 32'(count), 32'h9999);
    checkOutput("pre_wrap_carry", 32'(carry), 32'h0);
    applyStimulus(0, 1, 1, 0, 16'h0000, 1);
    checkOutput("wrap_up_count", 32'(count), 32'h0000);
    checkOutput("wrap_up_carry", 32'(carry), 32'h1);
    checkOutput("pin_model_carry", 32'(m_carry), 32'h1);
    applyStimulus(0, 1, 1, 0, 16'h0000, 1);
    checkOutput("wrap_up_carry_gone", 32'(carry), 32'h0);

    applyStimulus(0, 0, 0, 1, 16'h0000, 1);
    applyStimulus(0, 1, 0, 0, 16'h0000, 4);
    checkOutput("wrap_down_count", 32'(count), 32'h9999);
    checkOutput("wrap_down_carry", 32'(carry), 32'h1);
    applyStimulus(0, 0, 0, 0, 16'h0000, 20);
    checkOutput("en_low_hold", 32'(count), 32'h9999);
    checkOutput("en_low_carry", 32'(carry), 32'h0);

    applyStimulus(0, 0, 1, 1, 16'h12AF, 1);
    checkOutput("load_invalid", 32'(count), 32'h1200);
    checkOutput("pin_model_1200", 32'(to_bcd(m_val)), 32'h1200);
    applyStimulus(0, 1, 1, 0, 16'h0000, 3);
    checkOutput("before_tick_1200", 32'(count), 32'h1200);
    applyStimulus(0, 1, 1, 1, 16'h0042, 1);
    checkOutput("load_beats_tick", 32'(count), 32'h0042);
    applyStimulus(0, 1, 1, 0, 16'h0000, 3);
    checkOutput("tick_div_cleared", 32'(count), 32'h0042);
    applyStimulus(0, 1, 1, 0, 16'h0000, 1);
    checkOutput("after_load_tick", 32'(count), 32'h0043);

    applyStimulus(0, 0, 0, 1, 16'h1000, 1);
    applyStimulus(0, 1, 0, 0, 16'h0000, 4);
    checkOutput("down_ripple_0999", 32'(count), 32'h0999);
    checkOutput("down_ripple_carry", 32'(carry), 32'h0);

    applyStimulus(1, 0, 1, 0, 16'h0000, 1);
    applyStimulus(0, 0, 1, 1, 16'h0305, 1);
    applyStimulus(0, 0, 1, 0, 16'h0000, 1);
    checkOutput("scan0_an",  32'(an),  32'hE);
    checkOutput("scan0_bcd", 32'(bcd), 32'h5);
    applyStimulus(0, 0, 1, 0, 16'h0000, 2);
    checkOutput("scan1_an",  32'(an),  32'hD);
    checkOutput("scan1_bcd", 32'(bcd), 32'h0);
    applyStimulus(0, 0, 1, 0, 16'h0000, 2);
    checkOutput("scan2_an",  32'(an),  32'hB);
    checkOutput("scan2_bcd", 32'(bcd), 32'h3);
    applyStimulus(0, 0, 1, 0, 16'h0000, 2);
    checkOutput("scan3_an",  32'(an),  32'(an_slot3));
    checkOutput("scan3_bcd", 32'(bcd), 32'h0);
    applyStimulus(0, 0, 1, 0, 16'h0000, 2);
    checkOutput("scan_wrap_an",  32'(an),  32'hE);
    checkOutput("scan_wrap_bcd", 32'(bcd), 32'h5);
    applyStimulus(0, 0, 1, 0, 16'h0000, 3);
    applyStimulus(1, 0, 1, 0, 16'h0000, 1);
    checkOutput("mid_scan_rst_an",  32'(an),  32'hE);
    checkOutput("mid_scan_rst_bcd", 32'(bcd), 32'h0);

    applyStimulus(0, 1, 1, 0, 16'h0000, 30);
    applyStimulus(0, 1, 0, 0, 16'h0000, 30);
    applyStimulus(0, 1, 0, 1, 16'h0100, 1);
    applyStimulus(0, 1, 0, 0, 16'h0000, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
